// File: rtl/sort8_stream_ctrl.sv
// Serial-to-parallel wrapper around an 8-input sorter: loads eight samples,
// sorts the registered bank in one cycle, then streams the result back out.
module sort8_stream_ctrl #(
   parameter int W          = 8,
   parameter bit DESCENDING = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         out_last,
   input  logic         out_ready,
   output logic         busy,
   output logic [3:0]   fill
);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      SORT = 2'd1,
      EMIT = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [2:0]   idx_q, idx_d;
   logic [3:0]   fill_q, fill_d;
   logic [W-1:0] in_reg_q [8];
   logic [W-1:0] in_reg_d [8];
   logic [W-1:0] res_q [8];
   logic [W-1:0] res_d [8];
   logic [W-1:0] sorted_s [8];
   logic [W-1:0] a_s, b_s;
   logic [2:0]   out_sel_s;

   // Sorter: odd-even transposition network, smallest value lands in slot 0.
   always_comb begin
      sorted_s = in_reg_q;
      a_s      = {W{1'b0}};
      b_s      = {W{1'b0}};
      for (int r = 0; r < 8; r++) begin
         for (int j = r % 2; j < 7; j += 2) begin
            a_s           = sorted_s[j];
            b_s           = sorted_s[j+1];
            sorted_s[j]   = (a_s < b_s) ? a_s : b_s;
            sorted_s[j+1] = (a_s < b_s) ? b_s : a_s;
         end
      end
   end

   // Next-state logic for the LOAD -> SORT -> EMIT sequence.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      fill_d   = fill_q;
      in_reg_d = in_reg_q;
      res_d    = res_q;
      case (state_q)
         LOAD: begin
            if (in_valid) begin
               in_reg_d[idx_q] = in_data;
               idx_d           = idx_q + 3'd1;
               fill_d          = fill_q + 4'd1;
               if (idx_q == 3'd7) begin
                  state_d = SORT;
               end else begin
                  state_d = LOAD;
               end
            end else begin
               state_d = LOAD;
            end
         end
         SORT: begin
            res_d   = sorted_s;
            idx_d   = 3'd0;
            state_d = EMIT;
         end
         EMIT: begin
            if (out_ready) begin
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = LOAD;
                  fill_d  = 4'd0;
               end else begin
                  state_d = EMIT;
               end
            end else begin
               state_d = EMIT;
            end
         end
         default: begin
            state_d = LOAD;
            idx_d   = 3'd0;
            fill_d  = 4'd0;
         end
      endcase
   end

   // State and bank registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD;
         idx_q   <= 3'd0;
         fill_q  <= 4'd0;
         for (int k = 0; k < 8; k++) begin
            in_reg_q[k] <= {W{1'b0}};
            res_q[k]    <= {W{1'b0}};
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         fill_q   <= fill_d;
         in_reg_q <= in_reg_d;
         res_q    <= res_d;
      end
   end

   // Outputs depend only on registered state, never on in_valid/out_ready.
   assign out_sel_s = DESCENDING ? (3'd7 - idx_q) : idx_q;
   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == EMIT);
   assign busy      = (state_q == SORT) || (state_q == EMIT);
   assign out_data  = (state_q == EMIT) ? res_q[out_sel_s] : {W{1'b0}};
   assign out_last  = (state_q == EMIT) && (idx_q == 3'd7);
   assign fill      = fill_q;

endmodule

// File: tb/tb_sort8_stream_ctrl.sv
// Self-checking bench: ascending and descending instances share one stimulus
// stream and are compared against a queue-sorted reference frame.
module tb_sort8_stream_ctrl;

   logic       clk = 1'b0;
   logic       reset, in_valid, out_ready;
   logic [7:0] in_data;
   logic       in_ready_a, out_valid_a, out_last_a, busy_a;
   logic [7:0] out_data_a;
   logic [3:0] fill_a;
   logic       in_ready_d, out_valid_d, out_last_d, busy_d;
   logic [7:0] out_data_d;
   logic [3:0] fill_d;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   sort8_stream_ctrl #(.W(8), .DESCENDING(1'b0)) dut_asc (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
      .out_last(out_last_a), .out_ready(out_ready), .busy(busy_a), .fill(fill_a)
   );

   sort8_stream_ctrl #(.W(8), .DESCENDING(1'b1)) dut_desc (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_d), .out_valid(out_valid_d), .out_data(out_data_d),
      .out_last(out_last_d), .out_ready(out_ready), .busy(busy_d), .fill(fill_d)
   );

   // Drives one frame starting and ending on a falling edge; returns cycles used.
   task automatic run_frame(input logic [7:0] d [8], input bit gappy, input int bp_at,
                            input int bp_len, input bit hold_valid, input int abort_at,
                            output int cycles);
      int exp_q[$];
      int acc, cyc, k, bp_left;
      bit v;
      exp_q = {};
      for (int i = 0; i < 8; i++) exp_q.push_back(int'(d[i]));
      exp_q.sort();
      acc = 0;
      cyc = 0;
      while (acc < 8) begin
         checks++;
         if (fill_a !== 4'(acc) || fill_d !== 4'(acc)) begin
            errors++;
            $display("FAIL fill_load: got %0d/%0d want %0d", fill_a, fill_d, acc);
         end
         checks++;
         if (in_ready_a !== 1'b1 || in_ready_d !== 1'b1 || busy_a !== 1'b0 || out_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL load_state: in_ready=%b busy=%b out_valid=%b want 1,0,0", in_ready_a, busy_a, out_valid_a);
         end
         v = gappy ? (cyc % 2 == 0) : 1'b1;
         in_valid = v;
         in_data  = v ? d[acc] : 8'($urandom);
         if (v) acc++;
         @(negedge clk);
         cyc++;
      end
      in_valid = hold_valid;
      in_data  = 8'($urandom);
      checks++;
      if (busy_a !== 1'b1 || busy_d !== 1'b1 || out_valid_a !== 1'b0 || out_valid_d !== 1'b0 ||
          in_ready_a !== 1'b0 || fill_a !== 4'd8) begin
         errors++;
         $display("FAIL sort_cycle: busy=%b out_valid=%b in_ready=%b fill=%0d want 1,0,0,8",
                  busy_a, out_valid_a, in_ready_a, fill_a);
      end
      @(negedge clk);
      cyc++;
      k = 0;
      bp_left = bp_len;
      while (k < 8) begin
         if (k == abort_at) begin
            cycles = cyc;
            return;
         end
         checks++;
         if (out_valid_a !== 1'b1 || out_valid_d !== 1'b1) begin
            errors++;
            $display("FAIL emit_valid: got %b/%b want 1 at sample %0d", out_valid_a, out_valid_d, k);
         end
         checks++;
         if (out_data_a !== 8'(exp_q[k])) begin
            errors++;
            $display("FAIL data_asc: got %0d want %0d at sample %0d", out_data_a, exp_q[k], k);
         end
         checks++;
         if (out_data_d !== 8'(exp_q[7-k])) begin
            errors++;
            $display("FAIL data_desc: got %0d want %0d at sample %0d", out_data_d, exp_q[7-k], k);
         end
         checks++;
         if (out_last_a !== (k == 7) || out_last_d !== (k == 7)) begin
            errors++;
            $display("FAIL out_last: got %b/%b want %b at sample %0d", out_last_a, out_last_d, (k == 7), k);
         end
         checks++;
         if (in_ready_a !== 1'b0 || busy_a !== 1'b1 || fill_a !== 4'd8 || fill_d !== 4'd8) begin
            errors++;
            $display("FAIL emit_state: in_ready=%b busy=%b fill=%0d want 0,1,8", in_ready_a, busy_a, fill_a);
         end
         if (k == bp_at && bp_left > 0) begin
            out_ready = 1'b0;
            bp_left--;
         end else begin
            out_ready = 1'b1;
            k++;
         end
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b1;
      checks++;
      if (in_ready_a !== 1'b1 || in_ready_d !== 1'b1 || out_valid_a !== 1'b0 || busy_a !== 1'b0 ||
          fill_a !== 4'd0 || fill_d !== 4'd0) begin
         errors++;
         $display("FAIL frame_end: in_ready=%b out_valid=%b busy=%b fill=%0d want 1,0,0,0",
                  in_ready_a, out_valid_a, busy_a, fill_a);
      end
      cycles = cyc;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'd0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (in_ready_a !== 1'b1 || in_ready_d !== 1'b1 || out_valid_a !== 1'b0 || out_last_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b out_last=%b want 1,0,0", in_ready_a, out_valid_a, out_last_a);
      end
      checks++;
      if (busy_a !== 1'b0 || busy_d !== 1'b0 || fill_a !== 4'd0 || fill_d !== 4'd0) begin
         errors++;
         $display("FAIL reset_busy_fill: busy=%b fill=%0d want 0,0", busy_a, fill_a);
      end
      checks++;
      if (out_data_a !== 8'd0 || out_data_d !== 8'd0) begin
         errors++;
         $display("FAIL reset_data: got %0d/%0d want 0", out_data_a, out_data_d);
      end
   endtask

   task automatic test_basic();
      logic [7:0] f [8];
      int cyc;
      f = '{8'd5, 8'd12, 8'd255, 8'd1, 8'd0, 8'd12, 8'd19, 8'd68};
      run_frame(f, 1'b0, -1, 0, 1'b0, -1, cyc);
      checks++;
      if (cyc !== 17) begin
         errors++;
         $display("FAIL basic_period: got %0d want 17", cyc);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] f [8];
      int cyc;
      f = '{8'd5, 8'd12, 8'd255, 8'd1, 8'd0, 8'd12, 8'd19, 8'd68};
      run_frame(f, 1'b0, 3, 3, 1'b0, -1, cyc);
      checks++;
      if (cyc !== 20) begin
         errors++;
         $display("FAIL bp_period: got %0d want 20", cyc);
      end
   endtask

   task automatic test_gappy();
      logic [7:0] f [8];
      int cyc;
      for (int i = 0; i < 8; i++) f[i] = 8'hFF;
      run_frame(f, 1'b1, -1, 0, 1'b0, -1, cyc);
      checks++;
      if (cyc !== 24) begin
         errors++;
         $display("FAIL gappy_period: got %0d want 24", cyc);
      end
   endtask

   task automatic test_reset_mid_load();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(negedge clk);
      end
      checks++;
      if (fill_a !== 4'd3) begin
         errors++;
         $display("FAIL partial_fill: got %0d want 3", fill_a);
      end
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (fill_a !== 4'd0 || fill_d !== 4'd0 || in_ready_a !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_load: fill=%0d in_ready=%b want 0,1", fill_a, in_ready_a);
      end
   endtask

   task automatic test_reset_mid_emit();
      logic [7:0] f [8];
      int cyc;
      for (int i = 0; i < 8; i++) f[i] = 8'($urandom);
      run_frame(f, 1'b0, -1, 0, 1'b0, 3, cyc);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (out_valid_a !== 1'b0 || out_valid_d !== 1'b0 || in_ready_a !== 1'b1 || fill_a !== 4'd0 ||
          out_last_a !== 1'b0 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_emit: out_valid=%b in_ready=%b fill=%0d busy=%b want 0,1,0,0",
                  out_valid_a, in_ready_a, fill_a, busy_a);
      end
      f = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      run_frame(f, 1'b0, -1, 0, 1'b0, -1, cyc);
   endtask

   task automatic test_back_to_back();
      logic [7:0] f [8];
      int cyc;
      for (int n = 0; n < 2; n++) begin
         for (int i = 0; i < 8; i++) f[i] = 8'($urandom);
         run_frame(f, 1'b0, -1, 0, 1'b1, -1, cyc);
         checks++;
         if (cyc !== 17) begin
            errors++;
            $display("FAIL b2b_period: frame %0d got %0d want 17", n, cyc);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_random();
      logic [7:0] f [8];
      int cyc;
      bit dups;
      for (int n = 0; n < 6; n++) begin
         dups = (n % 2 == 1);
         for (int i = 0; i < 8; i++) f[i] = dups ? 8'($urandom_range(0, 3)) : 8'($urandom);
         run_frame(f, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), -1, cyc);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_gappy();
      test_reset_mid_load();
      test_reset_mid_emit();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
